collision_scheduler: RTL and testbench

Per-frame collision sequencer for the STG playfield. On each frame strobe it snapshots the player, moon and Hecatia coordinates. It then walks the bullet table through a single shared squared-distance unit and resolves one prioritised hit per frame. It also owns the post-hit invulnerability window, so the game-state logic only consumes a single `hit` pulse per frame.

---
 rtl/stg_pkg.sv | 33 +++
 rtl/diff_square.sv | 23 ++
 rtl/collision_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_collision_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stg_pkg.sv
// Shared types and constants for the STG playfield collision logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stg_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BOX,
        ST_MOON_DX,
        ST_MOON_DY,
        ST_BUL_REQ,
        ST_BUL_WAIT,
        ST_BUL_DX,
        ST_BUL_DY,
        ST_DONE
    } state_e;

    // hit_src codes
    localparam logic [1:0] HIT_BOSS   = 2'd0;
    localparam logic [1:0] HIT_MOON   = 2'd1;
    localparam logic [1:0] HIT_BULLET = 2'd2;
    localparam logic [1:0] HIT_NONE   = 2'd3;

    // Hecatia hitbox: hx-11 <= px < hx+12, hy-19 <= py < hy+20.
    // 12-bit signed so the box edges never wrap near the playfield border.
    localparam logic signed [11:0] BOX_X_LO = 12'sd11;
    localparam logic signed [11:0] BOX_X_HI = 12'sd12;
    localparam logic signed [11:0] BOX_Y_LO = 12'sd19;
    localparam logic signed [11:0] BOX_Y_HI = 12'sd20;

endpackage

// File: rtl/diff_square.sv
// Squared difference of two unsigned coordinates: sq_o = (a_i - b_i)^2.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i - unsigned coordinates; sq_o - unsigned square, exact (no wrap).
module diff_square
    import stg_pkg::*;
(
    input  logic [COORD_W-1:0]   a_i,
    input  logic [COORD_W-1:0]   b_i,
    output logic [2*COORD_W-1:0] sq_o
);

    logic signed [COORD_W:0] diff;
    logic        [COORD_W:0] neg_diff;
    logic        [COORD_W-1:0] mag;

    // One extra bit keeps the difference exact; its magnitude always fits COORD_W bits.
    assign diff     = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
    assign neg_diff = -diff;
    assign mag      = diff[COORD_W] ? neg_diff[COORD_W-1:0] : diff[COORD_W-1:0];
    assign sq_o     = {{COORD_W{1'b0}}, mag} * {{COORD_W{1'b0}}, mag};

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision sequencer: snapshot, boss box, moon and bullet distance checks, one prioritised hit.
// Latency: done/hit at 4*NUM_BULLETS+4 cycles after the accepted frame_start; fixed regardless of slot validity.
// Backpressure: none; frame_start while busy is dropped and flagged on overrun.
// Ports: clk/rst (sync, active-high); frame_start strobe; player/moon/hecatia coordinates;
//        bul_addr out with bul_x/bul_y/bul_valid returned one cycle later;
//        busy, done, hit, hit_src, hit_idx, invuln, overrun status.
module collision_scheduler
    import stg_pkg::*;
#(
    parameter int NUM_BULLETS   = 16,
    parameter int MOON_R2       = 3600,
    parameter int BULLET_R2     = 64,
    parameter int INVULN_FRAMES = 120
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [COORD_W-1:0]             moon_x,
    input  logic [COORD_W-1:0]             moon_y,
    input  logic [COORD_W-1:0]             hecatia_x,
    input  logic [COORD_W-1:0]             hecatia_y,
    output logic [$clog2(NUM_BULLETS)-1:0] bul_addr,
    input  logic [COORD_W-1:0]             bul_x,
    input  logic [COORD_W-1:0]             bul_y,
    input  logic                           bul_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           hit,
    output logic [1:0]                     hit_src,
    output logic [$clog2(NUM_BULLETS)-1:0] hit_idx,
    output logic                           invuln,
    output logic                           overrun
);

    localparam int IDX_W = $clog2(NUM_BULLETS);
    localparam int CNT_W = $clog2(INVULN_FRAMES + 2);
    localparam logic [20:0]      MOON_R2_W = 21'(MOON_R2);
    localparam logic [20:0]      BUL_R2_W  = 21'(BULLET_R2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BULLETS - 1);
    localparam logic [CNT_W-1:0] INV_LOAD  = CNT_W'(INVULN_FRAMES);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   px_q, py_q, mx_q, my_q, hx_q, hy_q;
    logic [COORD_W-1:0]   bx_q, by_q;
    logic                 bv_q;
    logic [20:0]          acc_q;
    logic                 found_q, found_d;
    logic [1:0]           src_q, src_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     addr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 inv_snap_q;
    logic                 done_q, hit_q, overrun_q;
    logic [1:0]           hit_src_q;
    logic [IDX_W-1:0]     hit_idx_q;

    logic [COORD_W-1:0]   sq_a, sq_b;
    logic [2*COORD_W-1:0] sq;
    logic [20:0]          sum;
    logic                 in_box;
    logic                 accept, last_slot, cnt_load, cnt_dec;
    logic signed [11:0]   px_s, py_s, hx_s, hy_s;

    // Single shared squaring unit; the state picks which pair it sees.
    always_comb begin
        sq_a = '0;
        sq_b = '0;
        case (state_q)
            ST_MOON_DX: begin sq_a = px_q; sq_b = mx_q; end
            ST_MOON_DY: begin sq_a = py_q; sq_b = my_q; end
            ST_BUL_DX:  begin sq_a = px_q; sq_b = bx_q; end
            ST_BUL_DY:  begin sq_a = py_q; sq_b = by_q; end
            default:    ;
        endcase
    end

    diff_square u_diff_square (
        .a_i  (sq_a),
        .b_i  (sq_b),
        .sq_o (sq)
    );

    assign sum = acc_q + {1'b0, sq};

    assign px_s = $signed({2'b00, px_q});
    assign py_s = $signed({2'b00, py_q});
    assign hx_s = $signed({2'b00, hx_q});
    assign hy_s = $signed({2'b00, hy_q});

    assign in_box = (px_s >= hx_s - BOX_X_LO) && (px_s < hx_s + BOX_X_HI) &&
                    (py_s >= hy_s - BOX_Y_LO) && (py_s < hy_s + BOX_Y_HI);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (frame_start) state_d = ST_BOX;
            ST_BOX:      state_d = ST_MOON_DX;
            ST_MOON_DX:  state_d = ST_MOON_DY;
            ST_MOON_DY:  state_d = ST_BUL_REQ;
            ST_BUL_REQ:  state_d = ST_BUL_WAIT;
            ST_BUL_WAIT: state_d = ST_BUL_DX;
            ST_BUL_DX:   state_d = ST_BUL_DY;
            ST_BUL_DY:   state_d = (addr_q == LAST_IDX) ? ST_DONE : ST_BUL_REQ;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Hit accumulator: a source is only recorded while nothing higher has hit,
    // which gives boss > moon > lowest bullet index by scan order alone.
    always_comb begin
        found_d = found_q;
        src_d   = src_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    found_d = 1'b0;
                    src_d   = HIT_NONE;
                    idx_d   = '0;
                end
            end
            ST_BOX: begin
                if (in_box) begin
                    found_d = 1'b1;
                    src_d   = HIT_BOSS;
                end
            end
            ST_MOON_DY: begin
                if (!found_q && (sum < MOON_R2_W)) begin
                    found_d = 1'b1;
                    src_d   = HIT_MOON;
                end
            end
            ST_BUL_DY: begin
                if (!found_q && bv_q && (sum < BUL_R2_W)) begin
                    found_d = 1'b1;
                    src_d   = HIT_BULLET;
                    idx_d   = addr_q;
                end
            end
            default: ;
        endcase
    end

    // The frame outcome is resolved on the last bullet step so done, hit and
    // the new hit_src/hit_idx all appear together in the DONE cycle.
    // Invulnerability is judged as it stood when the frame was accepted, so the
    // strobe that brings the counter to zero still shields its own frame.
    assign last_slot = (state_q == ST_BUL_DY) && (addr_q == LAST_IDX);
    assign accept    = last_slot && found_d && !inv_snap_q;
    assign cnt_load  = accept;
    assign cnt_dec   = (state_q == ST_IDLE) && frame_start && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            px_q       <= '0;
            py_q       <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            hx_q       <= '0;
            hy_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            bv_q       <= 1'b0;
            acc_q      <= '0;
            found_q    <= 1'b0;
            src_q      <= HIT_NONE;
            idx_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            inv_snap_q <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            overrun_q  <= 1'b0;
            hit_src_q  <= HIT_NONE;
            hit_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            found_q   <= found_d;
            src_q     <= src_d;
            idx_q     <= idx_d;
            done_q    <= last_slot;
            hit_q     <= accept;
            overrun_q <= frame_start && (state_q != ST_IDLE);

            if (cnt_load) begin
                cnt_q <= INV_LOAD;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        px_q       <= player_x;
                        py_q       <= player_y;
                        mx_q       <= moon_x;
                        my_q       <= moon_y;
                        hx_q       <= hecatia_x;
                        hy_q       <= hecatia_y;
                        addr_q     <= '0;
                        inv_snap_q <= (cnt_q != '0);
                    end
                end
                ST_MOON_DX, ST_BUL_DX: acc_q <= {1'b0, sq};
                ST_BUL_WAIT: begin
                    bx_q <= bul_x;
                    by_q <= bul_y;
                    bv_q <= bul_valid;
                end
                ST_BUL_DY: addr_q <= addr_q + IDX_W'(1);
                default: ;
            endcase

            if (last_slot) begin
                if (accept) begin
                    hit_src_q <= src_d;
                    hit_idx_q <= (src_d == HIT_BULLET) ? idx_d : '0;
                end else begin
                    hit_src_q <= HIT_NONE;
                    hit_idx_q <= '0;
                end
            end
        end
    end

    assign bul_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign hit      = hit_q;
    assign hit_src  = hit_src_q;
    assign hit_idx  = hit_idx_q;
    assign invuln   = (cnt_q != '0);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a one-cycle-latency bullet RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_collision_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [9:0] player_x, player_y, moon_x, moon_y, hecatia_x, hecatia_y;
    logic [3:0] bul_addr;
    logic [9:0] bul_x, bul_y;
    logic       bul_valid;
    logic       busy, done, hit, invuln, overrun;
    logic [1:0] hit_src;
    logic [3:0] hit_idx;

    logic [9:0] ram_x [16];
    logic [9:0] ram_y [16];
    logic       ram_v [16];

    int n_vec  = 0;
    int n_miss = 0;

    collision_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .player_x    (player_x),
        .player_y    (player_y),
        .moon_x      (moon_x),
        .moon_y      (moon_y),
        .hecatia_x   (hecatia_x),
        .hecatia_y   (hecatia_y),
        .bul_addr    (bul_addr),
        .bul_x       (bul_x),
        .bul_y       (bul_y),
        .bul_valid   (bul_valid),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .hit_src     (hit_src),
        .hit_idx     (hit_idx),
        .invuln      (invuln),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Bullet RAM: data for the address presented in one cycle appears the next.
    always @(posedge clk) begin
        bul_x     <= ram_x[bul_addr];
        bul_y     <= ram_y[bul_addr];
        bul_valid <= ram_v[bul_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic scene(input int px, input int py, input int mx, input int my,
                         input int hx, input int hy);
        player_x  = 10'(px);
        player_y  = 10'(py);
        moon_x    = 10'(mx);
        moon_y    = 10'(my);
        hecatia_x = 10'(hx);
        hecatia_y = 10'(hy);
    endtask

    task automatic clear_bullets();
        for (int i = 0; i < 16; i++) begin
            ram_x[i] = 10'd0;
            ram_y[i] = 10'd0;
            ram_v[i] = 1'b0;
        end
    endtask

    task automatic set_bullet(input int slot, input int x, input int y, input logic v);
        ram_x[slot] = 10'(x);
        ram_y[slot] = 10'(y);
        ram_v[slot] = v;
    endtask

    // Accepts one frame and waits (bounded) for done. dcyc is the cycle offset
    // from the accepting edge C0 at which done was seen (200 = timed out).
    task automatic run_frame(input int ovr_at, input bit chk_addr, output int dcyc,
                             output logic h, output logic [1:0] src,
                             output logic [3:0] idx, output logic inv);
        int c;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        c = 1;
        while (done !== 1'b1 && c < 200) begin
            if (chk_addr && c >= 4 && ((c - 4) % 4) == 0)
                chk("bul_addr_seq", 32'(bul_addr), 32'((c - 4) / 4));
            if (ovr_at != 0 && c == ovr_at) begin
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
                c++;
                chk("overrun_pulse", 32'(overrun), 32'd1);
            end else begin
                tick();
                c++;
            end
        end
        dcyc = c;
        h    = hit;
        src  = hit_src;
        idx  = hit_idx;
        inv  = invuln;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         dc, nh, ns, seen;
        logic       h, iv;
        logic [1:0] s;
        logic [3:0] ix;

        rst = 1'b1;
        frame_start = 1'b0;
        scene(0, 0, 900, 900, 900, 900);
        clear_bullets();
        do_reset();

        // Reset state
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_done",    32'(done),     32'd0);
        chk("rst_hit",     32'(hit),      32'd0);
        chk("rst_src",     32'(hit_src),  32'd3);
        chk("rst_idx",     32'(hit_idx),  32'd0);
        chk("rst_addr",    32'(bul_addr), 32'd0);
        chk("rst_invuln",  32'(invuln),   32'd0);
        chk("rst_overrun", 32'(overrun),  32'd0);

        // Moon hit: 30^2 + 40^2 = 2500 < 3600
        scene(100, 100, 130, 140, 900, 900);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("moon_done_cyc", 32'(dc), 32'd68);
        chk("moon_hit",      32'(h),  32'd1);
        chk("moon_src",      32'(s),  32'd1);
        chk("moon_idx",      32'(ix), 32'd0);
        chk("moon_invuln",   32'(iv), 32'd1);
        chk("idle_busy",     32'(busy), 32'd0);

        // Moon boundary: 36^2 + 48^2 = 3600, not strictly below
        do_reset();
        scene(100, 100, 136, 148, 900, 900);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("moon_edge_hit", 32'(h), 32'd0);
        chk("moon_edge_src", 32'(s), 32'd3);
        chk("moon_edge_inv", 32'(iv), 32'd0);

        // Large difference: 1015^2 = 1030225, must not wrap into a hit
        scene(5, 5, 1020, 5, 900, 900);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("moon_far_hit", 32'(h), 32'd0);
        chk("moon_far_src", 32'(s), 32'd3);

        // Bullet priority: slot 2 valid at distance^2 64 (no hit), slots 3/5
        // overlap but invalid, slot 7 valid overlap (32), slot 9 later also hits.
        do_reset();
        scene(100, 100, 600, 600, 900, 900);
        clear_bullets();
        set_bullet(2, 108, 100, 1'b1);
        set_bullet(3, 104, 104, 1'b0);
        set_bullet(5, 104, 104, 1'b0);
        set_bullet(7, 104, 104, 1'b1);
        set_bullet(9, 101, 101, 1'b1);
        run_frame(0, 1, dc, h, s, ix, iv);
        chk("bul_done_cyc", 32'(dc), 32'd68);
        chk("bul_hit",      32'(h),  32'd1);
        chk("bul_src",      32'(s),  32'd2);
        chk("bul_idx",      32'(ix), 32'd7);

        // Boss near origin: box spans x -6..16, y -14..24; moon and slot 0 also hit
        do_reset();
        scene(0, 0, 30, 30, 5, 5);
        clear_bullets();
        set_bullet(0, 1, 1, 1'b1);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("boss_hit", 32'(h),  32'd1);
        chk("boss_src", 32'(s),  32'd0);
        chk("boss_idx", 32'(ix), 32'd0);

        // Box edges: right edge exclusive, left/top edges inclusive
        do_reset();
        clear_bullets();
        scene(512, 500, 900, 100, 500, 500);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("box_right_src", 32'(s), 32'd3);
        scene(489, 481, 900, 100, 500, 500);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("box_lowedge_src", 32'(s), 32'd0);

        // Invulnerability: continuous moon overlap
        do_reset();
        scene(100, 100, 130, 140, 900, 900);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("inv_f1_hit", 32'(h), 32'd1);
        chk("inv_f1_src", 32'(s), 32'd1);
        nh = 0;
        ns = 0;
        for (int f = 2; f <= 121; f++) begin
            run_frame((f == 2) ? 10 : 0, 0, dc, h, s, ix, iv);
            if (h) nh++;
            if (s != 2'd3) ns++;
            if (f == 2) begin
                chk("ovr_done_cyc", 32'(dc), 32'd68);
                chk("ovr_src",      32'(s),  32'd3);
            end
            if (f == 120) chk("inv_f120", 32'(iv), 32'd1);
            if (f == 121) chk("inv_f121", 32'(iv), 32'd0);
        end
        chk("inv_quiet_hits", 32'(nh), 32'd0);
        chk("inv_quiet_src",  32'(ns), 32'd0);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("inv_f122_hit", 32'(h),  32'd1);
        chk("inv_f122_src", 32'(s),  32'd1);
        chk("inv_f122_inv", 32'(iv), 32'd1);

        // Reset mid-scan at C0+30 while invulnerable
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (29) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy",   32'(busy),     32'd0);
        chk("mid_rst_done",   32'(done),     32'd0);
        chk("mid_rst_addr",   32'(bul_addr), 32'd0);
        chk("mid_rst_src",    32'(hit_src),  32'd3);
        chk("mid_rst_invuln", 32'(invuln),   32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (80) begin
            tick();
            if (done) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        run_frame(0, 0, dc, h, s, ix, iv);
        chk("post_rst_done_cyc", 32'(dc), 32'd68);
        chk("post_rst_hit",      32'(h),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
